// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scancode decoder: tracks held state of 29 keys from make/break
// sequences, with press/release pulses, last-key index and held-key count.
module ps2_key_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic [7:0]  recievedData,
    input  logic        recievedNewData,
    input  logic        clear_all,
    output logic [28:0] key_state,
    output logic        key_press_pulse,
    output logic        key_release_pulse,
    output logic [4:0]  last_key,
    output logic [4:0]  keys_held
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StBreak, StExt, StExtBreak} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [28:0]       key_state_q, key_state_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic [4:0]        last_key_q, last_key_d;
    logic [4:0]        keys_held_q, keys_held_d;
    logic [5:0]        lookup;
    logic              hit;
    logic [4:0]        idx;

    // Returns {hit, index} for the 29 mapped make codes.
    function automatic logic [5:0] map_code(input logic [7:0] code);
        unique case (code)
            8'h0E: map_code = {1'b1, 5'd0};
            8'h16: map_code = {1'b1, 5'd1};
            8'h1E: map_code = {1'b1, 5'd2};
            8'h26: map_code = {1'b1, 5'd3};
            8'h25: map_code = {1'b1, 5'd4};
            8'h2E: map_code = {1'b1, 5'd5};
            8'h36: map_code = {1'b1, 5'd6};
            8'h3D: map_code = {1'b1, 5'd7};
            8'h3E: map_code = {1'b1, 5'd8};
            8'h46: map_code = {1'b1, 5'd9};
            8'h45: map_code = {1'b1, 5'd10};
            8'h4E: map_code = {1'b1, 5'd11};
            8'h55: map_code = {1'b1, 5'd12};
            8'h66: map_code = {1'b1, 5'd13};
            8'h0D: map_code = {1'b1, 5'd14};
            8'h15: map_code = {1'b1, 5'd15};
            8'h1D: map_code = {1'b1, 5'd16};
            8'h24: map_code = {1'b1, 5'd17};
            8'h2D: map_code = {1'b1, 5'd18};
            8'h2C: map_code = {1'b1, 5'd19};
            8'h35: map_code = {1'b1, 5'd20};
            8'h3C: map_code = {1'b1, 5'd21};
            8'h43: map_code = {1'b1, 5'd22};
            8'h44: map_code = {1'b1, 5'd23};
            8'h4D: map_code = {1'b1, 5'd24};
            8'h54: map_code = {1'b1, 5'd25};
            8'h5B: map_code = {1'b1, 5'd26};
            8'h5D: map_code = {1'b1, 5'd27};
            8'h29: map_code = {1'b1, 5'd28};
            default: map_code = 6'd0;
        endcase
    endfunction

    assign lookup = map_code(recievedData);
    assign hit    = lookup[5];
    assign idx    = lookup[4:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_state_d = key_state_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        last_key_d  = last_key_q;

        if (clear_all) begin
            state_d     = StIdle;
            cnt_d       = '0;
            key_state_d = '0;
        end else if (recievedNewData) begin
            cnt_d = '0;
            unique case (state_q)
                StIdle: begin
                    if (recievedData == 8'hF0) begin
                        state_d = StBreak;
                    end else if (recievedData == 8'hE0) begin
                        state_d = StExt;
                    end else if (hit) begin
                        if (!key_state_q[idx]) begin
                            press_d    = 1'b1;
                            last_key_d = idx;
                        end
                        key_state_d[idx] = 1'b1;
                    end
                end
                StBreak: begin
                    state_d = StIdle;
                    if (hit) begin
                        if (key_state_q[idx]) begin
                            release_d  = 1'b1;
                            last_key_d = idx;
                        end
                        key_state_d[idx] = 1'b0;
                    end
                end
                StExt:      state_d = (recievedData == 8'hF0) ? StExtBreak : StIdle;
                StExtBreak: state_d = StIdle;
                default:    state_d = StIdle;
            endcase
        end else if (state_q != StIdle) begin
            // Abandon a dangling prefix after TIMEOUT_CYCLES byte-free cycles.
            if (cnt_q == CntLast) begin
                state_d = StIdle;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_comb begin
        keys_held_d = '0;
        for (int i = 0; i < 29; i++) begin
            keys_held_d = keys_held_d + 5'(key_state_d[i]);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            key_state_q <= '0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            last_key_q  <= '0;
            keys_held_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_state_q <= key_state_d;
            press_q     <= press_d;
            release_q   <= release_d;
            last_key_q  <= last_key_d;
            keys_held_q <= keys_held_d;
        end
    end

    assign key_state         = key_state_q;
    assign key_press_pulse   = press_q;
    assign key_release_pulse = release_q;
    assign last_key          = last_key_q;
    assign keys_held         = keys_held_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: make/break, typematic, extended codes,
// prefix timeout, clear_all and mid-sequence reset.
module tb_ps2_key_decoder;

    logic        clk;
    logic        resetn;
    logic [7:0]  data;
    logic        new_data;
    logic        clear_all;
    logic [28:0] key_state;
    logic        press;
    logic        rel;
    logic [4:0]  last_key;
    logic [4:0]  keys_held;

    int checks;
    int failures;

    ps2_key_decoder #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .CLOCK_50         (clk),
        .resetn           (resetn),
        .recievedData     (data),
        .recievedNewData  (new_data),
        .clear_all        (clear_all),
        .key_state        (key_state),
        .key_press_pulse  (press),
        .key_release_pulse(rel),
        .last_key         (last_key),
        .keys_held        (keys_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge, after the
    // rising edge that consumed the byte.
    task automatic send_byte(input logic [7:0] b);
        data     = b;
        new_data = 1'b1;
        @(negedge clk);
        new_data = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        resetn    = 1'b0;
        data      = 8'h00;
        new_data  = 1'b0;
        clear_all = 1'b0;
        idle(2);

        // Strobe while in reset must not change anything.
        send_byte(8'h15);
        check_eq("rst_key_state", 32'(key_state), 32'h0);
        check_eq("rst_press", 32'(press), 32'h0);
        check_eq("rst_release", 32'(rel), 32'h0);
        check_eq("rst_last_key", 32'(last_key), 32'h0);
        check_eq("rst_keys_held", 32'(keys_held), 32'h0);
        resetn = 1'b1;
        idle(1);

        // Basic make/break of key 15.
        send_byte(8'h15);
        check_eq("make15_state", 32'(key_state), 32'h0000_8000);
        check_eq("make15_press", 32'(press), 32'h1);
        check_eq("make15_release", 32'(rel), 32'h0);
        check_eq("make15_last", 32'(last_key), 32'd15);
        check_eq("make15_held", 32'(keys_held), 32'd1);
        idle(1);
        check_eq("make15_pulse_end", 32'(press), 32'h0);
        send_byte(8'hF0);
        check_eq("f0_state_kept", 32'(key_state), 32'h0000_8000);
        check_eq("f0_no_release", 32'(rel), 32'h0);
        send_byte(8'h15);
        check_eq("brk15_state", 32'(key_state), 32'h0);
        check_eq("brk15_release", 32'(rel), 32'h1);
        check_eq("brk15_press", 32'(press), 32'h0);
        check_eq("brk15_held", 32'(keys_held), 32'd0);
        idle(1);
        check_eq("brk15_pulse_end", 32'(rel), 32'h0);

        // Typematic repeat of 0x29 (key 28), interleaved with key 1.
        send_byte(8'h29);
        check_eq("make28_press", 32'(press), 32'h1);
        check_eq("make28_last", 32'(last_key), 32'd28);
        send_byte(8'h29);
        check_eq("rep28_press", 32'(press), 32'h0);
        send_byte(8'h16);
        check_eq("make1_last", 32'(last_key), 32'd1);
        send_byte(8'h29);
        check_eq("rep28b_press", 32'(press), 32'h0);
        check_eq("rep28b_last", 32'(last_key), 32'd1);
        check_eq("rep28b_state", 32'(key_state), 32'h1000_0002);
        check_eq("rep28b_held", 32'(keys_held), 32'd2);
        send_byte(8'hF0);
        send_byte(8'h29);
        check_eq("brk28_release", 32'(rel), 32'h1);
        check_eq("brk28_last", 32'(last_key), 32'd28);
        send_byte(8'hF0);
        send_byte(8'h16);
        check_eq("brk1_state", 32'(key_state), 32'h0);
        // Break of a key not held: no pulse.
        send_byte(8'hF0);
        send_byte(8'h16);
        check_eq("brk_unheld_release", 32'(rel), 32'h0);

        // Extended sequences leave key_state alone.
        send_byte(8'hE0);
        send_byte(8'h15);
        check_eq("ext_make_state", 32'(key_state), 32'h0);
        check_eq("ext_make_press", 32'(press), 32'h0);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h15);
        check_eq("ext_brk_state", 32'(key_state), 32'h0);
        check_eq("ext_brk_release", 32'(rel), 32'h0);
        send_byte(8'h15);
        check_eq("post_ext_press", 32'(press), 32'h1);
        send_byte(8'hF0);
        send_byte(8'h15);
        check_eq("post_ext_release", 32'(rel), 32'h1);

        // Prefix timeout: 16 byte-free cycles abandon F0.
        send_byte(8'hF0);
        idle(16);
        send_byte(8'h16);
        check_eq("timeout_make_state", 32'(key_state), 32'h0000_0002);
        check_eq("timeout_make_press", 32'(press), 32'h1);
        // 15 byte-free cycles: prefix still live.
        send_byte(8'hF0);
        idle(15);
        send_byte(8'h16);
        check_eq("notimeout_state", 32'(key_state), 32'h0);
        check_eq("notimeout_release", 32'(rel), 32'h1);

        // clear_all with a concurrent byte.
        send_byte(8'h15);
        send_byte(8'h1D);
        send_byte(8'h24);
        check_eq("three_held", 32'(keys_held), 32'd3);
        check_eq("three_state", 32'(key_state), 32'h0003_8000);
        clear_all = 1'b1;
        send_byte(8'h2D);
        clear_all = 1'b0;
        check_eq("clr_state", 32'(key_state), 32'h0);
        check_eq("clr_held", 32'(keys_held), 32'd0);
        check_eq("clr_press", 32'(press), 32'h0);
        check_eq("clr_release", 32'(rel), 32'h0);
        check_eq("clr_last", 32'(last_key), 32'd17);
        // clear_all while in BREAK returns to IDLE.
        send_byte(8'hF0);
        clear_all = 1'b1;
        idle(1);
        clear_all = 1'b0;
        send_byte(8'h15);
        check_eq("clr_brk_make", 32'(press), 32'h1);

        // Reset mid-sequence after F0; key 15 is held at this point.
        send_byte(8'hF0);
        #1;
        resetn = 1'b0;
        #1;
        check_eq("async_rst_state", 32'(key_state), 32'h0);
        check_eq("async_rst_last", 32'(last_key), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        send_byte(8'h15);
        check_eq("post_rst_state", 32'(key_state), 32'h0000_8000);
        check_eq("post_rst_press", 32'(press), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Press and release pulses must never coincide.
    always @(negedge clk) begin
        if (resetn && press && rel) begin
            failures++;
            $display("FAIL pulse_overlap: got 1 expected 0");
        end
    end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2500000, cycles allowed between a prefix byte (F0/E0) and its follow-up byte before the prefix is abandoned.
REQ-002 CLOCK_50  input  1  system clock; all state updates on its rising edge.
REQ-003 resetn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 recievedData  input  8  scancode byte from the PS2 controller; valid only while recievedNewData=1.
REQ-005 recievedNewData  input  1  one-cycle strobe marking a new byte, synchronous to CLOCK_50.
REQ-006 clear_all  input  1  synchronous request to release every held key.
REQ-007 key_state  output  29  held-key vector, 1=held; bit map in REQ-011.
REQ-008 key_press_pulse  output  1  one-cycle pulse on a new press of a mapped key.
REQ-009 key_release_pulse  output  1  one-cycle pulse on release of a held mapped key.
REQ-010 last_key  output  5  index of the key in the most recent press/release event; keys_held output 5, popcount of key_state.

Function
REQ-011 Map, index:code: 0:0E, 1:16, 2:1E, 3:26, 4:25, 5:2E, 6:36, 7:3D, 8:3E, 9:46, 10:45, 11:4E, 12:55, 13:66, 14:0D, 15:15, 16:1D, 17:24, 18:2D, 19:2C, 20:35, 21:3C, 22:43, 23:44, 24:4D, 25:54, 26:5B, 27:5D, 28:29.
REQ-012 FSM states: IDLE, BREAK, EXT, EXT_BREAK; bytes consumed only on cycles with recievedNewData=1.
REQ-013 IDLE: F0 -> BREAK; E0 -> EXT; mapped code -> make event, stay IDLE; any other byte ignored, stay IDLE.
REQ-014 BREAK: mapped code -> break event, -> IDLE; any other byte (including F0, E0) ignored, -> IDLE.
REQ-015 EXT: F0 -> EXT_BREAK; any other byte ignored (extended make), -> IDLE.
REQ-016 EXT_BREAK: any byte ignored (extended break), -> IDLE; extended codes never alter key_state even when the low byte matches REQ-011.
REQ-017 Make event on key k: key_state[k] set; if key_state[k] was 0, key_press_pulse=1 and last_key=k; if already 1 (typematic repeat), no pulse, last_key unchanged.
REQ-018 Break event on key k: key_state[k] cleared; if key_state[k] was 1, key_release_pulse=1 and last_key=k; if already 0, no pulse.
REQ-019 Latency: key_state, pulses, last_key registered; they reflect a byte on the cycle after its recievedNewData strobe; pulses are high for exactly one cycle.
REQ-020 Timeout counter runs in BREAK, EXT, EXT_BREAK; cleared on each accepted byte; after TIMEOUT_CYCLES cycles with no byte, FSM -> IDLE, no key change.
REQ-021 clear_all=1: key_state -> 0, FSM -> IDLE, counter cleared, any byte in the same cycle discarded, no pulses, last_key unchanged.
REQ-022 keys_held registered, equals popcount of key_state with the same one-cycle timing as key_state; range 0..29.
REQ-023 key_press_pulse and key_release_pulse never both high in one cycle.

Reset
REQ-024 resetn=0 asynchronously forces: FSM IDLE, counter 0, key_state 0, key_press_pulse 0, key_release_pulse 0, last_key 0, keys_held 0.
REQ-025 Reset mid-sequence (e.g. after F0) discards the prefix; the first byte after release of reset is decoded from IDLE.
REQ-026 No output changes while resetn=0, regardless of recievedNewData.

Verification
REQ-027 Byte 15 -> key_state[15]=1, key_press_pulse one cycle, last_key=15, keys_held=1; then F0,15 -> key_state[15]=0, key_release_pulse one cycle, keys_held=0.
REQ-028 Bytes 29,29,29 (typematic) -> one key_press_pulse only, key_state[28]=1; F0,29 -> one release pulse.
REQ-029 Bytes E0,15 and E0,F0,15 -> key_state unchanged (0), no pulses, FSM back in IDLE.
REQ-030 F0 then no byte for TIMEOUT_CYCLES (bench override 16) -> FSM IDLE; next byte 16 is a make (key_state[1]=1), not a break.
REQ-031 Hold 1C-free set 15,1D,24 -> keys_held=3; clear_all together with byte 2D strobe -> key_state=0, keys_held=0, no pulse, key 18 not set.
REQ-032 Send F0, assert resetn=0 mid-stream, release, send 15 -> key_state[15]=1 with press pulse.
